// File: rtl/tmds_serializer_multi_if.sv
// Parallel input side of the multi-lane TMDS serializer: per-lane pixel bytes,
// control bits and the blanking flag, plus the character-rate sampling strobe.
interface tmds_serializer_multi_if #(
  parameter int CHANNELS = 3
);
  logic [8*CHANNELS-1:0] pixel_data;
  logic                  blanking;
  logic [2*CHANNELS-1:0] ctrl;
  logic                  pixel_ready;

  modport master (
    output pixel_data,
    output blanking,
    output ctrl,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  blanking,
    input  ctrl,
    output pixel_ready
  );
endinterface

// File: rtl/tmds_serializer_multi.sv
// Multi-lane DVI TMDS encoder and serializer: one 10-bit character per lane every
// 10/BITS_PER_CLK cycles, shifted out LSB first, BITS_PER_CLK bits per cycle.
module tmds_serializer_multi #(
  parameter int CHANNELS     = 3,
  parameter int BITS_PER_CLK = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  tmds_serializer_multi_if.slave          bus,
  output logic [BITS_PER_CLK*CHANNELS-1:0] dout,
  output logic                            char_start
);

  localparam int L = 10 / BITS_PER_CLK;

  if (BITS_PER_CLK != 1 && BITS_PER_CLK != 2 && BITS_PER_CLK != 5) begin : g_bad_bits_per_clk
    $error("tmds_serializer_multi: BITS_PER_CLK must be 1, 2 or 5");
  end

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  logic [3:0]            count_reg;
  logic                  loaded_reg;
  logic [8*CHANNELS-1:0] data_reg;
  logic                  blank_reg;
  logic [2*CHANNELS-1:0] ctrl_reg;
  logic                  load;

  assign load            = (count_reg == 4'(L - 1));
  assign bus.pixel_ready = load;
  // loaded_reg keeps char_start low until a real word has been loaded after reset
  assign char_start      = loaded_reg && (count_reg == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= 4'd0;
      loaded_reg <= 1'b0;
      data_reg   <= '0;
      blank_reg  <= 1'b1;
      ctrl_reg   <= '0;
    end else begin
      count_reg <= load ? 4'd0 : count_reg + 4'd1;
      if (load) begin
        loaded_reg <= 1'b1;
        data_reg   <= bus.pixel_data;
        blank_reg  <= bus.blanking;
        ctrl_reg   <= bus.ctrl;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    logic [7:0]        d;
    logic [3:0]        n1_d;
    logic              use_xnor;
    logic [8:0]        q_m;
    logic [3:0]        n1_q;
    logic [3:0]        n0_q;
    logic signed [5:0] diff;
    logic signed [5:0] delta;
    logic signed [5:0] cnt_sum;
    logic [9:0]        video_word;
    logic [9:0]        blank_word;
    logic [9:0]        load_word;
    logic signed [4:0] cnt_reg;
    logic signed [4:0] cnt_next;
    logic [9:0]        shift_reg;

    assign d = data_reg[8*gi +: 8];

    always_comb begin
      n1_d     = popcount8(d);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
      q_m      = '0;
      q_m[0]   = d[0];
      for (int i = 1; i < 8; i++) begin
        q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
      end
      q_m[8] = ~use_xnor;
      n1_q   = popcount8(q_m[7:0]);
      n0_q   = 4'd8 - n1_q;
      diff   = $signed({2'b00, n1_q}) - $signed({2'b00, n0_q});

      // DC-balance: pick inverted or plain q_m depending on running disparity
      video_word = '0;
      delta      = '0;
      if ((cnt_reg == 5'sd0) || (n1_q == n0_q)) begin
        video_word = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
        delta      = q_m[8] ? diff : -diff;
      end else if (((cnt_reg > 5'sd0) && (n1_q > n0_q)) ||
                   ((cnt_reg < 5'sd0) && (n0_q > n1_q))) begin
        video_word = {1'b1, q_m[8], ~q_m[7:0]};
        delta      = (q_m[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        video_word = {1'b0, q_m[8], q_m[7:0]};
        delta      = diff - (q_m[8] ? 6'sd0 : 6'sd2);
      end
      cnt_sum  = $signed({cnt_reg[4], cnt_reg}) + delta;
      cnt_next = cnt_sum[4:0];
    end

    always_comb begin
      blank_word = 10'b1101010100;
      case (ctrl_reg[2*gi +: 2])
        2'b00:   blank_word = 10'b1101010100;
        2'b01:   blank_word = 10'b0010101011;
        2'b10:   blank_word = 10'b0101010100;
        default: blank_word = 10'b1010101011;
      endcase
    end

    assign load_word = blank_reg ? blank_word : video_word;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg   <= 5'sd0;
        shift_reg <= '0;
      end else if (load) begin
        shift_reg <= load_word;
        cnt_reg   <= blank_reg ? 5'sd0 : cnt_next;
      end else begin
        shift_reg <= shift_reg >> BITS_PER_CLK;
      end
    end

    assign dout[BITS_PER_CLK*gi +: BITS_PER_CLK] = shift_reg[BITS_PER_CLK-1:0];
  end

endmodule

// File: tb/tb_tmds_serializer_multi.sv
// Directed bench: a 1-bit/clk and a 2-bit/clk instance, three lanes each, checked
// against hand-computed TMDS words, strobe timing and reset behaviour.
module tb_tmds_serializer_multi;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] dout1;
  logic       cs1;
  logic [5:0] dout2;
  logic       cs2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_serializer_multi_if #(.CHANNELS(3)) bus1 ();
  tmds_serializer_multi_if #(.CHANNELS(3)) bus2 ();

  tmds_serializer_multi #(.CHANNELS(3), .BITS_PER_CLK(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dout(dout1), .char_start(cs1)
  );

  tmds_serializer_multi #(.CHANNELS(3), .BITS_PER_CLK(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dout(dout2), .char_start(cs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures one character from the 1-bit instance; optionally scrambles the
  // inputs on non-ready cycles and restores them before the ready edge.
  task automatic get_char1(input string tag, input bit toggle,
                           output logic [9:0] w0, output logic [9:0] w1, output logic [9:0] w2);
    int n;
    logic [9:0]  rmask;
    logic [9:0]  smask;
    logic [23:0] sd;
    logic        sb;
    logic [5:0]  sc;
    n = 0;
    while (cs1 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    sd = bus1.pixel_data;
    sb = bus1.blanking;
    sc = bus1.ctrl;
    for (int i = 0; i < 10; i++) begin
      w0[i]    = dout1[0];
      w1[i]    = dout1[1];
      w2[i]    = dout1[2];
      rmask[i] = bus1.pixel_ready;
      smask[i] = cs1;
      if (toggle && i >= 1 && i <= 7) begin
        bus1.pixel_data = 24'($urandom);
        bus1.blanking   = 1'($urandom);
        bus1.ctrl       = 6'($urandom);
      end
      if (toggle && i == 8) begin
        bus1.pixel_data = sd;
        bus1.blanking   = sb;
        bus1.ctrl       = sc;
      end
      if (i < 9) tick();
    end
    check({tag, " ready_mask"}, 32'(rmask), 32'h200);
    check({tag, " start_mask"}, 32'(smask), 32'h001);
    $display("%s: lane words %h %h %h", tag, w0, w1, w2);
  endtask

  task automatic get_char2(input string tag,
                           output logic [9:0] w0, output logic [9:0] w1, output logic [9:0] w2);
    int n;
    logic [4:0] rmask;
    logic [4:0] smask;
    n = 0;
    while (cs2 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      w0[2*i] = dout2[0]; w0[2*i+1] = dout2[1];
      w1[2*i] = dout2[2]; w1[2*i+1] = dout2[3];
      w2[2*i] = dout2[4]; w2[2*i+1] = dout2[5];
      rmask[i] = bus2.pixel_ready;
      smask[i] = cs2;
      if (i < 4) tick();
    end
    check({tag, " ready_mask"}, 32'(rmask), 32'h10);
    check({tag, " start_mask"}, 32'(smask), 32'h01);
    $display("%s: lane words %h %h %h", tag, w0, w1, w2);
  endtask

  task automatic check_words(input string tag, input logic [9:0] w0, input logic [9:0] w1,
                             input logic [9:0] w2, input logic [9:0] e0, input logic [9:0] e1,
                             input logic [9:0] e2);
    check({tag, " lane0"}, 32'(w0), 32'(e0));
    check({tag, " lane1"}, 32'(w1), 32'(e1));
    check({tag, " lane2"}, 32'(w2), 32'(e2));
  endtask

  initial begin
    int n;
    logic [9:0] w0, w1, w2;

    rst = 1'b1;
    bus1.blanking = 1'b1; bus1.ctrl = 6'b0; bus1.pixel_data = 24'h0;
    bus2.blanking = 1'b1; bus2.ctrl = 6'b0; bus2.pixel_data = 24'h0;
    repeat (3) tick();
    check("rst dout1", 32'(dout1), 32'h0);
    check("rst ready1", 32'(bus1.pixel_ready), 32'h0);
    check("rst start1", 32'(cs1), 32'h0);
    check("rst dout2", 32'(dout2), 32'h0);

    rst = 1'b0;
    n = 0;
    while (bus1.pixel_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("latency1", 32'(n), 32'd9);

    // blanking words with lane ctrl 01/10/11
    bus1.ctrl = 6'b11_10_01;
    get_char1("c1", 1'b0, w0, w1, w2);
    check_words("c1", w0, w1, w2, 10'h354, 10'h354, 10'h354);

    bus1.blanking = 1'b0; bus1.pixel_data = 24'h00FF00;
    get_char1("c2", 1'b0, w0, w1, w2);
    check_words("c2", w0, w1, w2, 10'h0AB, 10'h154, 10'h2AB);

    get_char1("c3", 1'b1, w0, w1, w2);
    check_words("c3", w0, w1, w2, 10'h100, 10'h200, 10'h100);

    bus1.pixel_data = 24'hFF0000;
    get_char1("c4", 1'b0, w0, w1, w2);
    check_words("c4", w0, w1, w2, 10'h3FF, 10'h0FF, 10'h3FF);

    bus1.pixel_data = 24'h01111E;
    get_char1("c5", 1'b0, w0, w1, w2);
    check_words("c5", w0, w1, w2, 10'h100, 10'h3FF, 10'h200);

    bus1.pixel_data = 24'h000000;
    get_char1("c6", 1'b0, w0, w1, w2);
    check_words("c6", w0, w1, w2, 10'h25F, 10'h10F, 10'h1FF);

    // abort the next character at phase 4
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst dout1", 32'(dout1), 32'h0);
    check("midrst start1", 32'(cs1), 32'h0);
    check("midrst ready1", 32'(bus1.pixel_ready), 32'h0);
    rst = 1'b0;
    bus1.blanking = 1'b0; bus1.ctrl = 6'b11_11_11; bus1.pixel_data = 24'h00FF00;
    n = 0;
    while (bus1.pixel_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("midrst latency1", 32'(n), 32'd9);
    get_char1("r1", 1'b0, w0, w1, w2);
    check_words("r1", w0, w1, w2, 10'h354, 10'h354, 10'h354);
    get_char1("r2", 1'b0, w0, w1, w2);
    check_words("r2", w0, w1, w2, 10'h100, 10'h200, 10'h100);

    // two bits per clock instance
    rst = 1'b1;
    bus2.blanking = 1'b1; bus2.ctrl = 6'b0; bus2.pixel_data = 24'h0;
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    while (bus2.pixel_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("latency2", 32'(n), 32'd4);
    bus2.blanking = 1'b0; bus2.pixel_data = 24'h01111E;
    get_char2("d1", w0, w1, w2);
    check_words("d1", w0, w1, w2, 10'h354, 10'h354, 10'h354);
    bus2.pixel_data = 24'h0000FF;
    get_char2("d2", w0, w1, w2);
    check_words("d2", w0, w1, w2, 10'h25F, 10'h10F, 10'h1FF);
    get_char2("d3", w0, w1, w2);
    check_words("d3", w0, w1, w2, 10'h200, 10'h100, 10'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_serializer_multi.md
TMDS_SERIALIZER_MULTI -- requirements
Module: tmds_serializer_multi

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent TMDS lanes.
REQ-002 Parameter BITS_PER_CLK, default 1: serial bits emitted per clk per lane; legal values 1, 2, 5.
REQ-003 clk  in  1: bit-rate clock; sole clock of the block.
REQ-004 rst  in  1: reset, synchronous, active-high.
REQ-005 pixel_data  in  8*CHANNELS: lane c byte at [8c+7:8c].
REQ-006 blanking  in  1: 1 = send control words on all lanes.
REQ-007 ctrl  in  2*CHANNELS: lane c {c1,c0} at [2c+1:2c].
REQ-008 pixel_ready  out  1: one-cycle strobe; inputs are sampled on the clk edge where it is 1.
REQ-009 dout  out  BITS_PER_CLK*CHANNELS: lane c bits at [BITS_PER_CLK*c +: BITS_PER_CLK]; lowest index is the earlier bit.
REQ-010 char_start  out  1: 1 in the cycle dout carries bit 0 of a new character.

Function
REQ-011 Character period L = 10/BITS_PER_CLK cycles; out-of-range BITS_PER_CLK is a compile-time error.
REQ-012 Phase counter counts 0..L-1 and wraps to 0; pixel_ready = (counter == L-1).
REQ-013 On the pixel_ready edge, the input register captures pixel_data, blanking and ctrl.
REQ-014 On the same edge, each lane shift register loads the 10-bit word encoded from the previous input-register contents.
REQ-015 Latency: data sampled at ready edge k starts on dout the cycle after ready edge k+1, bit 0 first.
REQ-016 Each non-load edge shifts every lane right by BITS_PER_CLK; dout is the low BITS_PER_CLK bits of the shift register.
REQ-017 char_start = (counter == 0), asserted with the loaded word's bit 0.
REQ-018 Video encoding is per DVI 1.0, stage 1: n1 = popcount(d); use XNOR if n1>4 or (n1==4 and d[0]==0), else XOR; q_m[8] = 1 for XOR, 0 for XNOR.
REQ-019 Stage 2, case cnt==0 or n1(q_m[7:0])==n0: q[9] = ~q_m[8]; q[8] = q_m[8]; q[7:0] = q_m[8] ? q_m : ~q_m; cnt += q_m[8] ? n1-n0 : n0-n1.
REQ-020 Stage 2, case (cnt>0 and n1>n0) or (cnt<0 and n0>n1): q[9] = 1; q[8] = q_m[8]; q[7:0] = ~q_m; cnt += 2*q_m[8] + n0-n1.
REQ-021 Stage 2, otherwise: q[9] = 0; q[8] = q_m[8]; q[7:0] = q_m; cnt += n1-n0 - 2*(~q_m[8]).
REQ-022 cnt is a per-lane 5-bit signed register, updated only on load edges.
REQ-023 Blanking word per {c1,c0}: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
REQ-024 A blanking load sets that lane's cnt to 0.
REQ-025 Lanes are fully independent; a change of blanking or ctrl mid-character has no effect until the next pixel_ready edge.
REQ-026 No input backpressure exists: pixel_ready occurs every L cycles unconditionally.

Reset
REQ-027 While rst=1 at an edge: counter=0, cnt=0, shift registers=0, input register = blanking with ctrl 00.
REQ-028 While rst=1 at an edge: dout=0, pixel_ready=0, char_start=0.
REQ-029 After rst deasserts, first pixel_ready occurs L-1 cycles later; first load is the ctrl-00 blanking word 1101010100.
REQ-030 rst mid-character aborts the character in the next cycle; partial words are discarded and not resumed.

Verification
REQ-031 BITS_PER_CLK=1: release rst, hold blanking=1 ctrl=00 -> pixel_ready every 10 cycles; dout lane stream 0,0,1,0,1,0,1,0,1,1 repeating.
REQ-032 blanking=0, data 0x00 on two consecutive characters from cnt=0 -> words 0x100 (cnt=-8), then 0x3FF (cnt=+2).
REQ-033 From cnt=0, data 0xFF -> word 0x200, cnt=-8.
REQ-034 BITS_PER_CLK=2, CHANNELS=3, distinct bytes per lane -> pixel_ready period 5; each lane emits its own word two bits per cycle; lanes match independent reference models.
REQ-035 Assert rst at counter=4 for 1 cycle -> dout=0 the next cycle; counter restarts; cnt=0; the next load is the ctrl-00 blanking word.
REQ-036 Toggle blanking and ctrl on non-ready cycles -> serial output unchanged until the cycle after the next pixel_ready edge.
